// File: rtl/grouped_or_reduce_pipe.sv
// grouped_or_reduce_pipe: splits a wide word into GROUPS groups of GW bits, OR-reduces each
// group, gates it with a per-group select and reports any-hit, lowest hit index, hit count and
// hit mask through a 2-stage valid/ready pipeline.
// Optional build macro GROUPED_OR_STICKY_EN adds a sticky hit accumulator cleared by sticky_clr.
module grouped_or_reduce_pipe #(
  parameter int unsigned GROUPS = 8,
  parameter int unsigned GW     = 32,
  localparam int unsigned IW    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int unsigned CW    = $clog2(GROUPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GROUPS*GW-1:0] in_data,
  input  logic [GROUPS-1:0]    in_sel,
  input  logic                 sticky_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [IW-1:0]        out_idx,
  output logic [CW-1:0]        out_cnt,
  output logic [GROUPS-1:0]    out_mask
);

  logic              v1_q, v2_q;
  logic [GROUPS-1:0] g1_d, g1_q;
  logic [GROUPS-1:0] mask_d, mask_q;
  logic              hit_d, hit_q;
  logic [IW-1:0]     idx_d, idx_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              adv1, adv2;

  // Handshake: a stage may load when it is empty or the stage after it is moving.
  always_comb begin
    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  // Per-group OR-reduce gated by the select bit.
  always_comb begin
    g1_d = '0;
    for (int i = 0; i < int'(GROUPS); i++) begin
      g1_d[i] = (|in_data[i*GW +: GW]) & in_sel[i];
    end
  end

  // Stage 1 register; data only captured for a valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      g1_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        g1_q <= g1_d;
      end
    end
  end

`ifdef GROUPED_OR_STICKY_EN
  logic [GROUPS-1:0] acc_q;

  // Clear takes priority over the previous accumulation, so a clear on a load yields g1 only.
  always_comb begin
    mask_d = g1_q | (sticky_clr ? '0 : acc_q);
  end

  // Accumulator follows every loaded mask; a clear without a load empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (adv2 && v1_q) begin
      acc_q <= mask_d;
    end else if (sticky_clr) begin
      acc_q <= '0;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;

  // Without the accumulator the mask is the stage-1 hit vector.
  always_comb begin
    mask_d = g1_q;
  end
`endif

  // Any-hit, lowest set index (descending scan so the lowest wins) and popcount of the mask.
  always_comb begin
    hit_d = |mask_d;
    idx_d = '0;
    cnt_d = '0;
    for (int i = int'(GROUPS) - 1; i >= 0; i--) begin
      if (mask_d[i]) begin
        idx_d = IW'(i);
      end
      cnt_d = cnt_d + CW'(mask_d[i]);
    end
  end

  // Stage 2 register; outputs hold their last loaded values while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      mask_q <= '0;
      hit_q  <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mask_q <= mask_d;
        hit_q  <= hit_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  // Outputs straight from stage-2 flops.
  always_comb begin
    out_valid = v2_q;
    out_hit   = hit_q;
    out_idx   = idx_q;
    out_cnt   = cnt_q;
    out_mask  = mask_q;
  end

endmodule

// File: tb/tb_grouped_or_reduce_pipe.sv
// Self-checking bench for grouped_or_reduce_pipe (GROUPS=8, GW=32) with a result scoreboard.
module tb_grouped_or_reduce_pipe;

  localparam int G  = 8;
  localparam int GW = 32;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int D  = G * GW;
  localparam int RW = 1 + IW + CW + G;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [D-1:0]  in_data = '0;
  logic [G-1:0]  in_sel = '0;
  logic          sticky_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_hit;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] out_cnt;
  logic [G-1:0]  out_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] sb_q[$];
  logic [G-1:0]  acc_m = '0;

  always #5 clk = ~clk;

  grouped_or_reduce_pipe #(.GROUPS(G), .GW(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .sticky_clr(sticky_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt),
    .out_mask  (out_mask)
  );

  // Reference model: {hit, idx, cnt, mask}; tracks the sticky accumulator when enabled.
  function automatic logic [RW-1:0] model(input logic [D-1:0] d, input logic [G-1:0] s,
                                          input bit clr);
    logic [G-1:0] m;
    int c;
    int ix;
    m = '0;
    for (int g = 0; g < G; g++) m[g] = (d[g*GW +: GW] != '0) && s[g];
`ifdef GROUPED_OR_STICKY_EN
    if (!clr) m = m | acc_m;
    acc_m = m;
`endif
    c  = 0;
    ix = -1;
    for (int g = 0; g < G; g++) begin
      if (m[g]) begin
        c++;
        if (ix < 0) ix = g;
      end
    end
    if (ix < 0) ix = 0;
    return {(m != '0), IW'(ix), CW'(c), m};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {out_hit, out_idx, out_cnt, out_mask};
  endfunction

  // Sends one word into an idle pipe and reports the observed result and latency (-1 = timeout).
  task automatic send_wait(input logic [D-1:0] d, input logic [G-1:0] s, input bit clr,
                           output int lat, output logic [RW-1:0] res);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_sel    = s;
    out_ready = 1'b1;
    #1;
    if (in_ready) sb_q.push_back(model(d, s, clr));
    @(negedge clk);
    in_valid   = 1'b0;
    sticky_clr = clr;
    lat = -1;
    res = '0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (out_valid) begin
        lat = k;
        res = observed();
        break;
      end
      @(negedge clk);
      sticky_clr = 1'b0;
    end
    sticky_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [D-1:0] d;
    bit stale;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_checks++;
    if ({out_valid, observed()} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {out_valid, observed()});
    end
    // Fill both stages under backpressure, then reset asynchronously.
    d = '0; d[2*GW] = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sel = '1; out_ready = 1'b0;
    @(negedge clk);
    d = '0; d[6*GW+1] = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL full_stall got in_ready,out_valid=%b want 01", {in_ready, out_valid});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_valid got %b want 0", out_valid);
    end
    sb_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 if (out_valid !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (stale) begin
      n_fail++; $display("FAIL stale_after_reset got out_valid=1 want 0");
    end
  endtask

  task automatic test_single_group();
    logic [D-1:0] d;
    logic [RW-1:0] res, exp;
    int lat;
    d = '0; d[3*GW+5] = 1'b1;
    send_wait(d, 8'hFF, 1'b0, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL latency got %0d want 2", lat); end
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL g3_hit got %h want %h", res, exp); end
    n_checks++;
    if (res !== {1'b1, 3'd3, 4'd1, 8'h08}) begin
      n_fail++; $display("FAIL g3_const got %h want %h", res, {1'b1, 3'd3, 4'd1, 8'h08});
    end
    send_wait(d, 8'hF7, 1'b0, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (res !== exp || lat !== 2) begin
      n_fail++; $display("FAIL g3_masked got %h lat %0d want %h lat 2", res, lat, exp);
    end
    n_checks++;
    if (res[RW-1 -: 1+IW+CW] !== '0) begin
      n_fail++; $display("FAIL nohit_const got %h want hit/idx/cnt 0", res);
    end
  endtask

  task automatic test_multi_group();
    logic [D-1:0] d;
    logic [RW-1:0] res, exp;
    int lat;
    d = '0; d[1*GW+31] = 1'b1; d[4*GW+7] = 1'b1; d[7*GW] = 1'b1;
    send_wait(d, 8'hFF, 1'b0, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (res !== exp || lat !== 2) begin
      n_fail++; $display("FAIL multi got %h lat %0d want %h lat 2", res, lat, exp);
    end
    n_checks++;
    if (res !== {1'b1, 3'd1, 4'd3, 8'h92}) begin
      n_fail++; $display("FAIL multi_const got %h want %h", res, {1'b1, 3'd1, 4'd3, 8'h92});
    end
  endtask

  task automatic test_back_to_back();
    logic [D-1:0] d;
    logic [G-1:0] s;
    logic [RW-1:0] exp;
    logic [3:0] pat;
    bit exp_rdy;
    int sent, rcvd, cyc;
    pat = 4'b1001;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 200) begin
      @(negedge clk);
      for (int g = 0; g < G; g++) d[g*GW +: GW] = ($urandom_range(0, 2) == 0) ? '0 : $urandom();
      s = 8'($urandom());
      in_valid  = (sent < 10);
      in_data   = d;
      in_sel    = s;
      out_ready = pat[3 - (cyc % 4)];
      #1;
      exp_rdy = !(sb_q.size() == 2 && !out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        rcvd++;
        n_checks++;
        if (observed() !== exp) begin
          n_fail++; $display("FAIL b2b_data word %0d got %h want %h", rcvd, observed(), exp);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(d, s, 1'b0));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (rcvd !== 10 || sb_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_count got %0d left %0d want 10 left 0", rcvd, sb_q.size());
    end
  endtask

  task automatic test_sticky();
    logic [D-1:0] d0, d4, d2;
    logic [RW-1:0] res, exp;
    logic [G-1:0] want2;
    int lat;
    // Restart so the accumulator starts empty.
    @(negedge clk); rst_n = 1'b0; acc_m = '0; sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    d0 = '0; d0[0] = 1'b1;
    d4 = '0; d4[4*GW+9] = 1'b1;
    d2 = '0; d2[2*GW+3] = 1'b1;
`ifdef GROUPED_OR_STICKY_EN
    want2 = 8'h11;
`else
    want2 = 8'h10;
`endif
    send_wait(d0, 8'hFF, 1'b0, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (res !== exp || res[G-1:0] !== 8'h01) begin
      n_fail++; $display("FAIL sticky_w1 got %h want %h mask 01", res, exp);
    end
    send_wait(d4, 8'hFF, 1'b0, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (res !== exp || res[G-1:0] !== want2) begin
      n_fail++; $display("FAIL sticky_w2 got %h want %h mask %h", res, exp, want2);
    end
    send_wait(d2, 8'hFF, 1'b1, lat, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (res !== exp || res !== {1'b1, 3'd2, 4'd1, 8'h04}) begin
      n_fail++; $display("FAIL sticky_clr got %h want %h", res, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_multi_group();
    test_back_to_back();
    test_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
